// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transmit feeder
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_ADDR_W = 4;

    // Feeder sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_t;

    // One queued transfer: slave-select address above data byte
    typedef struct packed {
        logic [SPI_ADDR_W-1:0] addr;
        logic [SPI_DATA_W-1:0] data;
    } spi_entry_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock FIFO with registered full/empty/level
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  push request and payload (ignored while full)
//   rd_en, rd_data  pop request; rd_data shows the head entry (first-word fall-through)
//   full, empty     registered status flags
//   level           registered entry count, 0..DEPTH
//   ovf             high in any cycle a push is attempted while full
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = SPI_ADDR_W + SPI_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             push;
    logic             pop;

    // Admission is judged on the registered full flag, so a pop in the same
    // cycle cannot make room for a push that arrives while full.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign ovf     = wr_en && full;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - queues {ss address, byte} pairs and issues them to an SPI master
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data     push one transfer into the queue
//   full, empty, level          registered queue status
//   busy                        SPI master busy flag
//   en_ms, ss_addr, data_out    registered drive to the SPI master
//   done                        one-cycle pulse per completed transfer
//   err_timeout                 sticky: master never went busy after en_ms
//   err_ovf                     sticky: push attempted while full
//   err_clr                     clears both sticky errors (a same-cycle new error wins)
module spi_tx_feeder
    import spi_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int DATA_W        = SPI_DATA_W,
    parameter int ADDR_W        = SPI_ADDR_W,
    parameter int START_TIMEOUT = 64,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     busy,
    output logic                     en_ms,
    output logic [ADDR_W-1:0]        ss_addr,
    output logic [DATA_W-1:0]        data_out,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_ovf,
    input  logic                     err_clr
);

    localparam int EW    = ADDR_W + DATA_W;
    localparam int TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    spi_state_t       state;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [EW-1:0]    head;
    logic             pop;
    logic             ovf_evt;
    logic             timeout_evt;

    // Only pop when the master is idle so the latched byte is taken at once.
    assign pop         = (state == ST_IDLE) && !empty && !busy;
    assign timeout_evt = (state == ST_ISSUE) && !busy && (to_cnt == TO_LAST);

    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({wr_addr, wr_data}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            err_timeout <= (err_timeout && !err_clr) || timeout_evt;
            err_ovf     <= (err_ovf && !err_clr) || ovf_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            en_ms    <= 1'b0;
            ss_addr  <= '0;
            data_out <= '0;
            done     <= 1'b0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        ss_addr  <= head[EW-1:DATA_W];
                        data_out <= head[DATA_W-1:0];
                        en_ms    <= 1'b1;
                        to_cnt   <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (busy) begin
                        to_cnt <= '0;
                        state  <= ST_XFER;
                    end else if (to_cnt == TO_LAST) begin
                        // Master never started: drop the byte without a done.
                        en_ms   <= 1'b0;
                        to_cnt  <= '0;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!busy) begin
                        en_ms   <= 1'b0;
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // GAP always lasts at least one cycle, even with GAP_CYCLES=0.
                    if (GAP_CYCLES <= 1 || gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    en_ms <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
